// File: rtl/harvos_dmem_pkg.sv
// Shared types and helpers for the HarvOS data-memory responder.
// Contents: fault-cause and FSM state enums, legal byte-enable list,
// be_legal() legality check and lane_mask() byte-lane expansion.
package harvos_dmem_pkg;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_RANGE = 2'd1,
    FC_BE    = 2'd2,
    FC_RO    = 2'd3
  } fault_cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned N_LEGAL_BE = 7;

  // Naturally aligned byte, halfword and word lane patterns.
  localparam logic [N_LEGAL_BE-1:0][3:0] LEGAL_BE = {
    4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL_BE; i++) begin
      if (LEGAL_BE[3'(i)] == be) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/harvos_dmem_sram.sv
// Single-port DEPTH_WORDS x 32 synchronous SRAM, byte write enables,
// one-cycle registered read. Contents are never reset.
// Ports: clk; re read enable; we[3:0] lane write enables; addr word index;
//        wdata store data; rdata read data (holds until the next read).
module harvos_dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Byte-lane writes.
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][0] <= wdata[7:0];
    if (we[1]) mem[addr][1] <= wdata[15:8];
    if (we[2]) mem[addr][2] <= wdata[23:16];
    if (we[3]) mem[addr][3] <= wdata[31:24];
  end

  // Read port only updates on an explicit read, so data survives wait states.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/harvos_dmem_slave.sv
// HarvOS data-memory responder: services load/store requests against the
// on-chip SRAM with a configurable number of wait states, answering with a
// one-cycle done or fault pulse and recording the last fault for the trap handler.
// Ports: clk, rst (sync, active-high); req/we/be/addr/wdata request held by
//        master until response; rdata load data in the done cycle; done/fault
//        response pulses; fault_addr/fault_cause last fault record.
module harvos_dmem_slave
  import harvos_dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RO_WORDS    = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [1:0]  fault_cause
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

  dmem_state_e  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;

  logic         cap_we;
  logic [3:0]   cap_be;
  logic [31:0]  cap_addr;
  logic [31:0]  cap_wdata;

  logic         done_q, fault_q;
  logic [31:0]  rmask_q;
  logic [31:0]  fault_addr_q;
  fault_cause_e fault_cause_q;

  logic         cur_we;
  logic [3:0]   cur_be;
  logic [31:0]  cur_addr;
  logic [31:0]  cur_wdata;
  logic [31:0]  cur_off;
  fault_cause_e cur_cause;
  logic         resp_go_c;
  logic         ok_c;
  logic [31:0]  sram_rdata;

  // In IDLE the live request is used (zero-wait responses and the SRAM read
  // happen on the capture edge); afterwards the captured copy is used.
  always_comb begin
    cur_we    = cap_we;
    cur_be    = cap_be;
    cur_addr  = cap_addr;
    cur_wdata = cap_wdata;
    if (state_q == S_IDLE) begin
      cur_we    = we;
      cur_be    = be;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

  assign cur_off = cur_addr - BASE_ADDR;

  // Access checks, highest priority first; addresses below BASE wrap high.
  always_comb begin
    cur_cause = FC_NONE;
    if (cur_off >= SPAN || cur_addr[1:0] != 2'b00) begin
      cur_cause = FC_RANGE;
    end else if (!be_legal(cur_be)) begin
      cur_cause = FC_BE;
    end else if (cur_we && (cur_off >> 2) < RO_WORDS) begin
      cur_cause = FC_RO;
    end
  end

  assign ok_c = (cur_cause == FC_NONE);

  // Edge that enters RESP: response flops and the store write happen here.
  assign resp_go_c = (state_q == S_IDLE && req && WAIT_STATES == 0) ||
                     (state_q == S_WAIT && cnt_q == 4'd0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      cap_we        <= 1'b0;
      cap_be        <= 4'd0;
      cap_addr      <= 32'd0;
      cap_wdata     <= 32'd0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      rmask_q       <= 32'd0;
      fault_addr_q  <= 32'd0;
      fault_cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        cap_we    <= we;
        cap_be    <= be;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      done_q  <= resp_go_c && ok_c;
      fault_q <= resp_go_c && !ok_c;
      rmask_q <= (resp_go_c && ok_c && !cur_we) ? lane_mask(cur_be) : 32'd0;
      if (resp_go_c && !ok_c) begin
        fault_addr_q  <= cur_addr;
        fault_cause_q <= cur_cause;
      end
    end
  end

  // Read on the capture edge; write only on a successful store entering RESP.
  harvos_dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .re    (state_q == S_IDLE && req && !rst),
    .we    ((resp_go_c && ok_c && cur_we && !rst) ? cur_be : 4'b0000),
    .addr  (cur_off[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (sram_rdata)
  );

  // Lane mask is nonzero only during a load's done cycle.
  assign rdata       = sram_rdata & rmask_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_harvos_dmem_slave.sv
// Directed bench for harvos_dmem_slave: one instance with no wait states and
// one with three, sharing clock, reset and request fields; sel picks which
// instance sees req and whose outputs are observed.
module tb_harvos_dmem_slave;

  logic        clk = 1'b0;
  logic        rst, req, we, sel;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic [31:0] rdata0, rdata1, fault_addr0, fault_addr1;
  logic        done0, done1, fault0, fault1;
  logic [1:0]  fault_cause0, fault_cause1;

  logic [31:0] o_rdata, o_fault_addr;
  logic        o_done, o_fault;
  logic [1:0]  o_fault_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  harvos_dmem_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req && !sel), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .done(done0), .fault(fault0),
    .fault_addr(fault_addr0), .fault_cause(fault_cause0)
  );

  harvos_dmem_slave #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .req(req && sel), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .done(done1), .fault(fault1),
    .fault_addr(fault_addr1), .fault_cause(fault_cause1)
  );

  assign o_rdata       = sel ? rdata1       : rdata0;
  assign o_done        = sel ? done1        : done0;
  assign o_fault       = sel ? fault1       : fault0;
  assign o_fault_addr  = sel ? fault_addr1  : fault_addr0;
  assign o_fault_cause = sel ? fault_cause1 : fault_cause0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access and wait (bounded) for its response; also checks the
  // cycle after the response is quiet.
  task automatic access(input string tag, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic r_done, output logic r_fault,
                        output logic [31:0] r_data);
    int i;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    lat = 0; r_done = 1'b0; r_fault = 1'b0; r_data = 32'd0; i = 0;
    while (lat == 0 && i < 20) begin
      @(posedge clk); #1;
      i++;
      if (o_done || o_fault) begin
        lat = i; r_done = o_done; r_fault = o_fault; r_data = o_rdata;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_quiet"}, {30'd0, o_done, o_fault}, 32'd0);
    check({tag, "_rdata0"}, o_rdata, 32'd0);
  endtask

  task automatic run(input string tag, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic exp_fault, input logic [31:0] exp_rdata,
                     input logic [1:0] exp_cause);
    int lat;
    logic rd, rf;
    logic [31:0] rv;
    access(tag, w, b, a, d, lat, rd, rf, rv);
    check({tag, "_lat"}, 32'(lat), sel ? 32'd4 : 32'd1);
    check({tag, "_resp"}, {30'd0, rf, rd}, exp_fault ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, rv, exp_rdata);
    if (exp_fault) begin
      check({tag, "_faddr"}, o_fault_addr, a);
      check({tag, "_fcause"}, {30'd0, o_fault_cause}, {30'd0, exp_cause});
    end
  endtask

  initial begin : main
    int cnt, first, last, lat, anyresp;
    logic found;

    sel = 1'b0; rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'd0;
    addr = 32'd0; wdata = 32'd0;
    dut0.u_sram.mem[0] = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst_out", {o_done, o_fault, o_fault_cause}, 32'd0);
      check("rst_rdata", o_rdata, 32'd0);
      check("rst_faddr", o_fault_addr, 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // No wait states: basic store/load and lane merge.
    run("st1",    1'b1, 4'b1111, 32'h2000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'd0);
    run("ld1",    1'b0, 4'b1111, 32'h2000_0100, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'd0);
    run("st_b1",  1'b1, 4'b0010, 32'h2000_0100, 32'h0000_AA00, 1'b0, 32'h0, 2'd0);
    run("ld_w",   1'b0, 4'b1111, 32'h2000_0100, 32'h0, 1'b0, 32'hDEAD_AAEF, 2'd0);
    run("ld_hi",  1'b0, 4'b1100, 32'h2000_0100, 32'h0, 1'b0, 32'hDEAD_0000, 2'd0);
    run("ld_b0",  1'b0, 4'b0001, 32'h2000_0100, 32'h0, 1'b0, 32'h0000_00EF, 2'd0);

    // Faults.
    run("f_below", 1'b0, 4'b1111, 32'h1FFF_FFFC, 32'h0, 1'b1, 32'h0, 2'd1);
    run("f_align", 1'b0, 4'b1111, 32'h2000_0102, 32'h0, 1'b1, 32'h0, 2'd1);
    run("f_be",    1'b0, 4'b0101, 32'h2000_0100, 32'h0, 1'b1, 32'h0, 2'd2);
    run("f_ro",    1'b1, 4'b1111, 32'h2000_0000, 32'h1111_1111, 1'b1, 32'h0, 2'd3);
    run("ld_ro",   1'b0, 4'b1111, 32'h2000_0000, 32'h0, 1'b0, 32'hCAFE_F00D, 2'd0);
    check("fhold_addr", o_fault_addr, 32'h2000_0000);
    check("fhold_cause", {30'd0, o_fault_cause}, 32'd3);

    // Boundaries: last RO word, first writable word, last word, one past end.
    run("f_ro_last", 1'b1, 4'b1111, 32'h2000_003C, 32'h1, 1'b1, 32'h0, 2'd3);
    run("st_rw0",    1'b1, 4'b1111, 32'h2000_0040, 32'h4040_4040, 1'b0, 32'h0, 2'd0);
    run("ld_rw0",    1'b0, 4'b1111, 32'h2000_0040, 32'h0, 1'b0, 32'h4040_4040, 2'd0);
    run("st_top",    1'b1, 4'b1111, 32'h2000_0FFC, 32'h5A5A_5A5A, 1'b0, 32'h0, 2'd0);
    run("ld_top",    1'b0, 4'b1111, 32'h2000_0FFC, 32'h0, 1'b0, 32'h5A5A_5A5A, 2'd0);
    run("f_end",     1'b0, 4'b1111, 32'h2000_1000, 32'h0, 1'b1, 32'h0, 2'd1);

    // Priority.
    run("p_rng_be",  1'b1, 4'b0000, 32'h2000_0001, 32'h0, 1'b1, 32'h0, 2'd1);
    run("p_rng_ro",  1'b1, 4'b1111, 32'h2000_1000, 32'h0, 1'b1, 32'h0, 2'd1);
    run("p_be0",     1'b1, 4'b0000, 32'h2000_0100, 32'h0, 1'b1, 32'h0, 2'd2);
    run("ld_after",  1'b0, 4'b1111, 32'h2000_0100, 32'h0, 1'b0, 32'hDEAD_AAEF, 2'd0);

    // Three wait states.
    sel = 1'b1;
    #0;
    run("w_st", 1'b1, 4'b1111, 32'h2000_0200, 32'h1111_2222, 1'b0, 32'h0, 2'd0);
    run("w_ld", 1'b0, 4'b1111, 32'h2000_0200, 32'h0, 1'b0, 32'h1111_2222, 2'd0);

    // req dropped after the sampling edge still completes.
    req = 1'b1; we = 1'b0; be = 4'b1111; addr = 32'h2000_0200;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; found = 1'b0;
    while (!found && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) begin
        found = 1'b1;
        check("drop_rdata", o_rdata, 32'h1111_2222);
      end
    end
    check("drop_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // req held high: one response every five cycles.
    req = 1'b1;
    cnt = 0; first = 0; last = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (o_done) begin
        cnt++;
        if (first == 0) first = i;
        last = i;
      end
    end
    req = 1'b0;
    check("hold_cnt", 32'(cnt), 32'd4);
    check("hold_first", 32'(first), 32'd4);
    check("hold_last", 32'(last), 32'd19);
    repeat (3) @(posedge clk);
    #1;

    // Reset lands on the edge that would have written the store.
    req = 1'b1; we = 1'b1; be = 4'b1111; addr = 32'h2000_0200; wdata = 32'h9999_9999;
    anyresp = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (o_done || o_fault) anyresp++;
      if (i == 3) begin rst = 1'b1; req = 1'b0; end
      if (i == 4) rst = 1'b0;
    end
    check("rst_no_resp", 32'(anyresp), 32'd0);
    check("rst_w_rdata", o_rdata, 32'd0);
    check("rst_w_faddr", o_fault_addr, 32'd0);
    check("rst_d0_faddr", fault_addr0, 32'd0);
    check("rst_d0_fcause", {30'd0, fault_cause0}, 32'd0);
    run("rst_ld", 1'b0, 4'b1111, 32'h2000_0200, 32'h0, 1'b0, 32'h1111_2222, 2'd0);
    run("w_fault", 1'b0, 4'b1111, 32'h1FFF_FFFC, 32'h0, 1'b1, 32'h0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
